// File: rtl/dmem_responder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dmem_responder: multi-cycle Y86 data memory, 8-byte little-endian access |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module dmem_responder #(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        rd,
   input  logic        wr,
   input  logic [63:0] mem_addr,
   input  logic [63:0] mem_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] valM,
   output logic        dmem_error
);

   localparam int          AW       = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
   localparam logic [64:0] DEPTH_65 = 65'(DEPTH_BYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic          rd_q;
   logic          wr_q;
   logic [63:0]   addr_q;
   logic [63:0]   data_q;

   logic [7:0]    mem [DEPTH_BYTES] = '{default: 8'h00};

   logic [64:0]   end_addr;
   logic          acc_err;
   logic          exec;
   logic          do_write;
   logic [AW-1:0] byte_idx [8];
   logic [63:0]   rdata;

   // End address is widened so addresses near 2^64 cannot wrap into range.
   assign end_addr = {1'b0, addr_q} + 65'd7;
   assign acc_err  = (end_addr >= DEPTH_65) || (rd_q && wr_q);
   assign exec     = (state == BUSY) && (cnt == 4'd0);
   assign do_write = exec && wr_q && !acc_err && !reset;

   for (genvar i = 0; i < 8; i++) begin : g_byte
      assign byte_idx[i]     = addr_q[AW-1:0] + AW'(i);
      assign rdata[8*i +: 8] = mem[byte_idx[i]];
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 8; i++) begin
            mem[byte_idx[i]] <= data_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         valM       <= 64'd0;
         dmem_error <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= 64'd0;
         data_q     <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  rd_q      <= rd;
                  wr_q      <= wr;
                  addr_q    <= mem_addr;
                  data_q    <= mem_data;
                  cnt       <= CNT_LOAD;
                  req_ready <= 1'b0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == 4'd0) begin
                  valM       <= (rd_q && !acc_err) ? rdata : 64'd0;
                  dmem_error <= acc_err;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Sequential Y86 data-memory responder: the memory end of the memory-stage interface. It accepts one read or write request per handshake using the `rd`, `wr`, `mem_addr` and `mem_data` signals that the memory stage's control logic produces. Each access is an unaligned little-endian 8-byte access to a byte array. After a programmable latency it returns `valM` and `dmem_error`. It replaces the combinational RAM model so the pipeline's stall logic can be exercised against a multi-cycle memory.

## Interface
Parameters:
- `DEPTH_BYTES`, default 1024: size of the byte array; valid byte addresses are 0 to DEPTH_BYTES-1.
- `LATENCY`, default 2: number of BUSY cycles per access; legal range 1 to 15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `rd`  in  1  read request; sampled on acceptance.
- `wr`  in  1  write request; sampled on acceptance.
- `mem_addr`  in  64  byte address of the lowest byte.
- `mem_data`  in  64  write data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `valM`  out  64  read data; 0 for writes, no-ops and errors.
- `dmem_error`  out  1  access fault for this response.

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - `req_ready`=1.
  - When `req_valid`=1, the request is accepted: `rd`, `wr`, `mem_addr` and `mem_data` are latched, the counter is loaded with LATENCY-1, and the FSM moves to BUSY.
- BUSY:
  - `req_ready`=0. The counter decrements each cycle.
  - On the edge where the counter is 0, the access executes, `valM` and `dmem_error` are registered, and the FSM moves to RESP.
- RESP:
  - `resp_valid`=1. `valM` and `dmem_error` are held stable.
  - When `resp_ready`=1, the FSM moves to IDLE.
- Error check is evaluated on the latched request:
  - The end address is computed in 65 bits as {1'b0,mem_addr}+7.
  - `dmem_error`=1 if that end address is at least DEPTH_BYTES, or if `rd` and `wr` are both 1.
  - On error, no bytes are written and `valM`=0.
- Read: valM[8i+7:8i] = mem[mem_addr+i] for i=0..7 (little-endian).
- Write: mem[mem_addr+i] = mem_data[8i+7:8i] for i=0..7. All 8 bytes commit on the same edge.
- No-op (`rd`=0, `wr`=0): the full handshake still completes, with `valM`=0 and `dmem_error`=0.
- Unaligned and overlapping accesses are legal; there is no alignment fault.
- Array contents are not affected by `reset`. Simulation initializes the array to all zeros.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `valM`=0, `dmem_error`=0, counter=0.
- Reset in BUSY or RESP returns the FSM to IDLE on that edge.
  - A write that has not yet committed is discarded.
  - A response that has not been taken is dropped.
- Latency:
  - The request is accepted at edge N.
  - The write commits, or `valM` is captured, at edge N+LATENCY.
  - `resp_valid` is high from cycle N+LATENCY onward.
- Response handshake: taken at the first edge where both `resp_valid` and `resp_ready` are 1. `req_ready` returns to 1 in the following cycle.
- Minimum issue interval is LATENCY+2 cycles when `resp_ready` is held at 1.
- `req_valid` in BUSY or RESP is ignored; the request is not latched.
- Inputs only need to be stable in the acceptance cycle; later changes have no effect.
- A read issued after a write returns the written data, since the write has committed before the read is accepted.

## Test plan
- **Reset defaults:** hold `reset` for 2 cycles -> `req_ready`=1, `resp_valid`=0, `valM`=0, `dmem_error`=0.
- **Aligned write then read (LATENCY=2):**
  - Stimulus: write 0x0123456789ABCDEF at 0x40, then read 0x40 with `resp_ready`=1.
  - Response: each `resp_valid` rises exactly 2 cycles after acceptance; the read returns 0x0123456789ABCDEF; byte 0x40 reads back as 0xEF.
- **Overlapping unaligned writes:**
  - Stimulus: for k=0..9, write value v_k at 0xFF+k; then read 0xFF and 0x108.
  - Response: read 0xFF = {v7[7:0], v6[7:0], ..., v0[7:0]}; read 0x108 = v9.
- **Out-of-range access (DEPTH_BYTES=1024):**
  - Stimulus: write at 0x3F9, write at 0xFFFFFFFFFFFFFFFC, and a request with `rd`=`wr`=1.
  - Response: `dmem_error`=1 and `valM`=0 for each; a following read of 0x3F8 is unchanged and `dmem_error`=0.
- **Backpressure and ignored request:**
  - Stimulus: hold `resp_ready`=0 for 5 cycles; pulse `req_valid` during RESP.
  - Response: `valM` and `resp_valid` are held stable; the extra request is not accepted; `req_ready` is 1 the cycle after `resp_ready` goes high.
- **Reset mid-BUSY:**
  - Stimulus: assert `reset` one cycle after accepting a write of 0xAAAA... at 0x80.
  - Response: FSM returns to IDLE; a later read of 0x80 returns the prior contents (0), not 0xAAAA....
